// File: rtl/cla_pkg.sv
// Shared constants and types for the lookahead subtractor datapath.
// Optional flags output is enabled by defining CLA_SUB_FLAGS_EN.
package cla_pkg;
  localparam int CLA_GROUP = 4;
  localparam int CLA_W = 32;
  localparam int CLA_HALF = CLA_W / 2;

  typedef struct packed {
    logic                carry;
    logic [CLA_HALF-1:0] sum;
  } half_res_t;
endpackage

// File: rtl/cla_addsub_16.sv
// Half-width carry-lookahead add/sub built from 4-bit lookahead groups.
// A group-level generator forms the carry into each group.
module cla_addsub_16
  import cla_pkg::*;
#(
  parameter int W = CLA_HALF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = W / CLA_GROUP;

  logic [W-1:0]  bx;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;

  assign bx = b ^ {W{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  always_comb begin
    gg = '0;
    gp = '1;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < CLA_GROUP; i++) begin
        gg[k] = g[k*CLA_GROUP+i]
              | (p[k*CLA_GROUP+i] & gg[k]);
        gp[k] = gp[k] & p[k*CLA_GROUP+i];
      end
    end
  end

  always_comb begin
    gc = '0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  // Bit carries inside a group start from that group's lookahead carry
  always_comb begin
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[k*CLA_GROUP] = gc[k];
      for (int i = 1; i < CLA_GROUP; i++) begin
        c[k*CLA_GROUP+i] = g[k*CLA_GROUP+i-1]
                         | (p[k*CLA_GROUP+i-1]
                            & c[k*CLA_GROUP+i-1]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];
endmodule

// File: rtl/cla_sub_32_pipe.sv
// Two-stage pipelined subtractor with valid/ready on both sides.
// Define CLA_SUB_FLAGS_EN to add registered ovf_out and zero_out.
module cla_sub_32_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_inp,
  input  logic [WIDTH-1:0] b_inp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             b_out
`ifdef CLA_SUB_FLAGS_EN
  ,
  output logic             ovf_out,
  output logic             zero_out
`endif
);
  localparam int HALF = WIDTH / 2;

  logic            s1_valid;
  logic [HALF-1:0] s1_lo;
  logic            s1_carry;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;

  logic [HALF-1:0] lo_sum;
  logic            lo_cout;
  logic [HALF-1:0] hi_sum;
  logic            hi_cout;

  logic accept;
  logic s2_adv;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  cla_addsub_16 #(.W(HALF)) u_lo (
    .a    (a_inp[HALF-1:0]),
    .b    (b_inp[HALF-1:0]),
    .cin  (1'b1),
    .sub  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_addsub_16 #(.W(HALF)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .cin  (s1_carry),
    .sub  (1'b1),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_lo    <= lo_sum;
      s1_carry <= lo_cout;
      s1_a_hi  <= a_inp[WIDTH-1:HALF];
      s1_b_hi  <= b_inp[WIDTH-1:HALF];
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Borrow is the inverted carry out of a + ~b + 1
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      b_out     <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      d_out     <= {hi_sum, s1_lo};
      b_out     <= ~hi_cout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CLA_SUB_FLAGS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_out  <= 1'b0;
      zero_out <= 1'b0;
    end else if (s2_adv) begin
      ovf_out  <= (s1_a_hi[HALF-1] != s1_b_hi[HALF-1])
               && (hi_sum[HALF-1] != s1_a_hi[HALF-1]);
      zero_out <= (hi_sum == '0) && (s1_lo == '0);
    end
  end
`endif
endmodule

// File: tb/tb_cla_sub_32_pipe.sv
// Directed and randomized checks of cla_sub_32_pipe
// against a plain-arithmetic reference queue.
module tb_cla_sub_32_pipe;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_inp;
  logic [31:0] b_inp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        b_out;
`ifdef CLA_SUB_FLAGS_EN
  logic        ovf_out;
  logic        zero_out;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t q[$];

  cla_sub_32_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_inp     (a_inp),
    .b_inp     (b_inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .b_out     (b_out)
`ifdef CLA_SUB_FLAGS_EN
    ,
    .ovf_out   (ovf_out),
    .zero_out  (zero_out)
`endif
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa;
    longint sb;
    longint sd;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sd   = sa - sb;
    e.d  = a - b;
    e.bo = (a < b);
    e.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.z  = (e.d == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic dir(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] ed,
                     input logic        eb);
    in_valid = 1'b1;
    a_inp    = a;
    b_inp    = b;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_d"}, d_out, ed);
    chk({tag, "_b"}, {31'd0, b_out}, {31'd0, eb});
  endtask

  initial begin
    exp_t e;
    logic        stall_prev;
    logic [31:0] prev_d;
    logic        prev_b;
    logic        acc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    a_inp     = '0;
    b_inp     = '0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_d", d_out, 32'd0);
    chk("rst_b", {31'd0, b_out}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    dir("basic", 32'd5, 32'd3, 32'd2, 1'b0);
    cyc();
    chk("drain_vld", {31'd0, out_valid}, 32'd0);
    chk("hold_d", d_out, 32'd2);
    dir("wrap", 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    cyc();
    dir("xhalf", 32'h0001_0000, 32'd1, 32'h0000_FFFF, 1'b0);
    cyc();

`ifdef CLA_SUB_FLAGS_EN
    dir("ovf", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
    chk("ovf_f", {31'd0, ovf_out}, 32'd1);
    chk("ovf_z", {31'd0, zero_out}, 32'd0);
    cyc();
    dir("zero", 32'd7, 32'd7, 32'd0, 1'b0);
    chk("zero_f", {31'd0, zero_out}, 32'd1);
    chk("zero_o", {31'd0, ovf_out}, 32'd0);
    cyc();
`endif

    // Backpressure: three pairs, output stalled for three edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_inp     = 32'd10;
    b_inp     = 32'd1;
    #1;
    chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
    cyc();
    a_inp = 32'd20;
    b_inp = 32'd2;
    #1;
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    cyc();
    a_inp = 32'd30;
    b_inp = 32'd3;
    #1;
    chk("bp_rdy2", {31'd0, in_ready}, 32'd0);
    chk("bp_d0", d_out, 32'd9);
    chk("bp_v0", {31'd0, out_valid}, 32'd1);
    cyc();
    chk("bp_rdy3", {31'd0, in_ready}, 32'd0);
    chk("bp_d1", d_out, 32'd9);
    out_ready = 1'b1;
    #1;
    chk("bp_rel", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_d2", d_out, 32'd18);
    chk("bp_v2", {31'd0, out_valid}, 32'd1);
    cyc();
    chk("bp_d3", d_out, 32'd27);
    chk("bp_v3", {31'd0, out_valid}, 32'd1);
    cyc();
    chk("bp_v4", {31'd0, out_valid}, 32'd0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_inp     = 32'd100;
    b_inp     = 32'd1;
    cyc();
    a_inp = 32'd200;
    b_inp = 32'd2;
    cyc();
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr_vld", {31'd0, out_valid}, 32'd0);
    chk("mr_d", d_out, 32'd0);
    chk("mr_rdy", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mr_stale", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic against the reference queue
    stall_prev = 1'b0;
    prev_d     = '0;
    prev_b     = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_inp     = $urandom;
      b_inp     = ($urandom_range(0, 7) == 0) ? a_inp : $urandom;
      #1;
      if (stall_prev) begin
        chk("rnd_hold_v", {31'd0, out_valid}, 32'd1);
        chk("rnd_hold_d", d_out, prev_d);
        chk("rnd_hold_b", {31'd0, b_out}, {31'd0, prev_b});
      end
      if (out_valid && out_ready) begin
        n_chk++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL rnd_extra observed=%h expected=none", d_out);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rnd_d", d_out, e.d);
          chk("rnd_b", {31'd0, b_out}, {31'd0, e.bo});
`ifdef CLA_SUB_FLAGS_EN
          chk("rnd_ovf", {31'd0, ovf_out}, {31'd0, e.ov});
          chk("rnd_zero", {31'd0, zero_out}, {31'd0, e.z});
`endif
        end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a_inp, b_inp));
      stall_prev = out_valid && !out_ready;
      prev_d     = d_out;
      prev_b     = b_out;
      cyc();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid && q.size() > 0) begin
        e = q.pop_front();
        chk("drn_d", d_out, e.d);
        chk("drn_b", {31'd0, b_out}, {31'd0, e.bo});
      end
      cyc();
    end
    chk("drn_left", q.size(), 32'd0);
    chk("drn_vld", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
